// File: rtl/pbch_pkg.sv
// -----------------------------------------------------------------------------
// pbch_pkg
// Shared definitions for the PBCH resource-grid address generator:
//   - PBCH_ADDR_W    : default grid-memory address width
//   - PBCH_ADDR_IDLE : address driven while no sweep is active (all ones)
//   - PBCH_SYM_BASE  : default per-symbol base addresses, symbol 0 in the LSBs
//   - pbch_state_e   : sweep FSM state encoding
//   - sym_count()    : number of present symbols in a 4-bit symbol mask
// -----------------------------------------------------------------------------
package pbch_pkg;

  localparam int PBCH_ADDR_W = 10;

  localparam logic [PBCH_ADDR_W-1:0] PBCH_ADDR_IDLE = {PBCH_ADDR_W{1'b1}};

  // Symbol 0 base sits in bits [9:0], symbol 3 base in bits [39:30].
  localparam logic [4*PBCH_ADDR_W-1:0] PBCH_SYM_BASE =
    {10'd576, 10'd336, 10'd240, 10'd0};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } pbch_state_e;

  function automatic logic [2:0] sym_count(input logic [3:0] mask);
    return {2'b00, mask[0]} + {2'b00, mask[1]} + {2'b00, mask[2]} + {2'b00, mask[3]};
  endfunction

endpackage

// File: rtl/pbch_addr_gen_if.sv
// -----------------------------------------------------------------------------
// pbch_addr_gen_if
// Request / address-stream bundle of the PBCH address generator.
//   start, dmrs_shift, out_rdy         : requester/consumer -> generator
//   addr_r, out_vld_r, grp_size_r,
//   grp_last_r, sc_idx_r, is_dmrs_r,
//   busy_r, addr_done_r                : generator -> consumer
// modport master : the generator (drives the address stream)
// modport slave  : the requester / downstream consumer
// -----------------------------------------------------------------------------
interface pbch_addr_gen_if #(
  parameter int ADDR_W = pbch_pkg::PBCH_ADDR_W,
  parameter int SC_W   = 8
);

  logic              start;
  logic [1:0]        dmrs_shift;
  logic              out_rdy;
  logic [ADDR_W-1:0] addr_r;
  logic              out_vld_r;
  logic [2:0]        grp_size_r;
  logic              grp_last_r;
  logic [SC_W-1:0]   sc_idx_r;
  logic              is_dmrs_r;
  logic              busy_r;
  logic              addr_done_r;

  modport master (
    input  start, dmrs_shift, out_rdy,
    output addr_r, out_vld_r, grp_size_r, grp_last_r, sc_idx_r, is_dmrs_r,
           busy_r, addr_done_r
  );

  modport slave (
    output start, dmrs_shift, out_rdy,
    input  addr_r, out_vld_r, grp_size_r, grp_last_r, sc_idx_r, is_dmrs_r,
           busy_r, addr_done_r
  );

endinterface

// File: rtl/pbch_sym_mask.sv
// -----------------------------------------------------------------------------
// pbch_sym_mask
// Combinational symbol-presence lookup for one subcarrier k.
//   k         in  : subcarrier index
//   cur_sym   in  : symbol currently being output (for next_sym)
//   mask      out : bit s set when symbol s holds PBCH data at k
//   first_sym out : lowest present symbol at k
//   last_sym  out : highest present symbol at k
//   next_sym  out : lowest present symbol above cur_sym at k
// -----------------------------------------------------------------------------
module pbch_sym_mask #(
  parameter int N_SYM   = 3,
  parameter int MID_SYM = 1,
  parameter int EDGE_LO = 48,
  parameter int EDGE_HI = 192,
  parameter int SC_W    = 8
) (
  input  logic [SC_W-1:0] k,
  input  logic [1:0]      cur_sym,
  output logic [3:0]      mask,
  output logic [1:0]      first_sym,
  output logic [1:0]      last_sym,
  output logic [1:0]      next_sym
);

  // One extra bit so an edge equal to 2**SC_W still compares correctly.
  localparam logic [SC_W:0] LO_K = EDGE_LO[SC_W:0];
  localparam logic [SC_W:0] HI_K = EDGE_HI[SC_W:0];

  logic in_gap_s;

  always_comb begin
    in_gap_s = ({1'b0, k} >= LO_K) && ({1'b0, k} < HI_K);
  end

  // Presence mask: every stored symbol except the middle one inside the gap.
  always_comb begin
    mask = 4'b0000;
    for (int s = 0; s < 4; s++) begin
      mask[s] = (s < N_SYM) && !((s == MID_SYM) && in_gap_s);
    end
  end

  // Priority searches over the mask; a descending scan leaves the lowest hit.
  always_comb begin
    first_sym = 2'd0;
    last_sym  = 2'd0;
    next_sym  = 2'd0;
    for (int s = 3; s >= 0; s--) begin
      first_sym = mask[s] ? 2'(s) : first_sym;
      next_sym  = (mask[s] && (2'(s) > cur_sym)) ? 2'(s) : next_sym;
    end
    for (int s = 0; s < 4; s++) begin
      last_sym = mask[s] ? 2'(s) : last_sym;
    end
  end

endmodule

// File: rtl/pbch_addr_gen.sv
// -----------------------------------------------------------------------------
// pbch_addr_gen
// Sweeps the stored PBCH resource grid subcarrier-major (k outer, symbol
// inner), skipping the punctured centre of MID_SYM, and emits one grid-memory
// read address per valid/ready handshake together with averaging-group info.
//   clk, rst : clock, synchronous active-high reset
//   bus      : pbch_addr_gen_if.master (start/dmrs_shift/out_rdy in,
//              addr_r/out_vld_r/grp_size_r/grp_last_r/sc_idx_r/is_dmrs_r/
//              busy_r/addr_done_r out, all outputs registered)
// -----------------------------------------------------------------------------
module pbch_addr_gen
  import pbch_pkg::*;
#(
  parameter int N_SC    = 240,
  parameter int N_SYM   = 3,
  parameter int MID_SYM = 1,
  parameter int EDGE_LO = 48,
  parameter int EDGE_HI = 192,
  parameter int ADDR_W  = PBCH_ADDR_W,
  parameter logic [4*ADDR_W-1:0] SYM_BASE = PBCH_SYM_BASE
) (
  input  logic            clk,
  input  logic            rst,
  pbch_addr_gen_if.master bus
);

  localparam int SC_W    = $clog2(N_SC);
  localparam int N_SC_M1 = N_SC - 1;
  localparam int GAP     = EDGE_HI - EDGE_LO;

  localparam logic [SC_W-1:0]   K_LAST    = N_SC_M1[SC_W-1:0];
  localparam logic [SC_W-1:0]   K_ONE     = 1;
  localparam logic [SC_W:0]     EDGE_HI_K = EDGE_HI[SC_W:0];
  localparam logic [ADDR_W-1:0] GAP_A     = GAP[ADDR_W-1:0];
  localparam logic [1:0]        MID_S     = MID_SYM[1:0];
  localparam logic [2:0]        N_SYM_C   = N_SYM[2:0];
  localparam logic [ADDR_W-1:0] ADDR_IDLE = {ADDR_W{1'b1}};

  // Highest address any present entry can reach must stay below the idle code.
  function automatic bit cfg_ok();
    bit ok;
    int top;
    ok = 1'b1;
    if (N_SYM < 1 || N_SYM > 4) ok = 1'b0;
    if (MID_SYM < 0 || MID_SYM >= N_SYM) ok = 1'b0;
    if (EDGE_LO < 0 || EDGE_LO > EDGE_HI || EDGE_HI > N_SC) ok = 1'b0;
    if (N_SYM == 1 && EDGE_LO != EDGE_HI) ok = 1'b0;
    if (N_SC < 2 || SC_W > ADDR_W || ADDR_W > 30) ok = 1'b0;
    for (int s = 0; s < 4; s++) begin
      if (s < N_SYM) begin
        top = int'(SYM_BASE[s*ADDR_W +: ADDR_W]) + N_SC - 1 - ((s == MID_SYM) ? GAP : 0);
        if (top > (1 << ADDR_W) - 2) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  localparam bit CFG_OK = cfg_ok();

  if (!CFG_OK) begin : g_cfg_err
    $error("pbch_addr_gen: parameter set is inconsistent or overflows ADDR_W");
  end

  // Entries of MID_SYM beyond the gap are packed down by the gap width.
  function automatic logic [ADDR_W-1:0] calc_addr(input logic [SC_W-1:0] k,
                                                  input logic [1:0]      s);
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] adj;
    base = SYM_BASE[s*ADDR_W +: ADDR_W];
    adj  = ((s == MID_S) && ({1'b0, k} >= EDGE_HI_K)) ? GAP_A : '0;
    return base + ADDR_W'(k) - adj;
  endfunction

  pbch_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              vld_q, vld_d;
  logic [2:0]        grp_size_q, grp_size_d;
  logic              grp_last_q, grp_last_d;
  logic [SC_W-1:0]   sc_idx_q, sc_idx_d;
  logic              is_dmrs_q, is_dmrs_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [1:0]        sym_q, sym_d;
  logic [1:0]        shift_q, shift_d;

  logic [SC_W-1:0]   k_inc_s;
  logic [SC_W-1:0]   k_eval_s;
  logic [3:0]        mask_s;
  logic [1:0]        first_s, last_s, next_s;
  logic              take_s;

  // The single lookup serves the next entry: same k inside a group, k+1 after
  // the group's last entry, and k=0 while waiting for start.
  always_comb begin
    k_inc_s = sc_idx_q + K_ONE;
    take_s  = vld_q && bus.out_rdy;
    if (state_q == ST_RUN && !grp_last_q) begin
      k_eval_s = sc_idx_q;
    end else if (state_q == ST_RUN) begin
      k_eval_s = k_inc_s;
    end else begin
      k_eval_s = '0;
    end
  end

  pbch_sym_mask #(
    .N_SYM   (N_SYM),
    .MID_SYM (MID_SYM),
    .EDGE_LO (EDGE_LO),
    .EDGE_HI (EDGE_HI),
    .SC_W    (SC_W)
  ) u_sym_mask (
    .k         (k_eval_s),
    .cur_sym   (sym_q),
    .mask      (mask_s),
    .first_sym (first_s),
    .last_sym  (last_s),
    .next_sym  (next_s)
  );

  // Next-state and next-output logic; holding everything is the default.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    vld_d      = vld_q;
    grp_size_d = grp_size_q;
    grp_last_d = grp_last_q;
    sc_idx_d   = sc_idx_q;
    is_dmrs_d  = is_dmrs_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    sym_d      = sym_q;
    shift_d    = shift_q;
    case (state_q)
      ST_IDLE: begin
        vld_d      = 1'b0;
        addr_d     = ADDR_IDLE;
        grp_last_d = 1'b0;
        busy_d     = 1'b0;
        if (bus.start) begin
          state_d    = ST_RUN;
          shift_d    = bus.dmrs_shift;
          sc_idx_d   = '0;
          sym_d      = first_s;
          addr_d     = calc_addr('0, first_s);
          vld_d      = 1'b1;
          grp_size_d = sym_count(mask_s);
          grp_last_d = (first_s == last_s);
          is_dmrs_d  = (bus.dmrs_shift == 2'd0);
          busy_d     = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (take_s && !grp_last_q) begin
          sym_d      = next_s;
          addr_d     = calc_addr(sc_idx_q, next_s);
          grp_last_d = (next_s == last_s);
        end else if (take_s && sc_idx_q != K_LAST) begin
          sc_idx_d   = k_inc_s;
          sym_d      = first_s;
          addr_d     = calc_addr(k_inc_s, first_s);
          grp_size_d = sym_count(mask_s);
          grp_last_d = (first_s == last_s);
          is_dmrs_d  = (k_inc_s[1:0] == shift_q);
        end else if (take_s) begin
          state_d    = ST_DONE;
          vld_d      = 1'b0;
          addr_d     = ADDR_IDLE;
          grp_last_d = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d    = ST_IDLE;
        vld_d      = 1'b0;
        addr_d     = ADDR_IDLE;
        grp_last_d = 1'b0;
        busy_d     = 1'b0;
      end
      default: begin
        state_d    = ST_IDLE;
        vld_d      = 1'b0;
        addr_d     = ADDR_IDLE;
        grp_last_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= ADDR_IDLE;
      vld_q      <= 1'b0;
      grp_size_q <= N_SYM_C;
      grp_last_q <= 1'b0;
      sc_idx_q   <= '0;
      is_dmrs_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sym_q      <= 2'd0;
      shift_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      vld_q      <= vld_d;
      grp_size_q <= grp_size_d;
      grp_last_q <= grp_last_d;
      sc_idx_q   <= sc_idx_d;
      is_dmrs_q  <= is_dmrs_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sym_q      <= sym_d;
      shift_q    <= shift_d;
    end
  end

  assign bus.addr_r      = addr_q;
  assign bus.out_vld_r   = vld_q;
  assign bus.grp_size_r  = grp_size_q;
  assign bus.grp_last_r  = grp_last_q;
  assign bus.sc_idx_r    = sc_idx_q;
  assign bus.is_dmrs_r   = is_dmrs_q;
  assign bus.busy_r      = busy_q;
  assign bus.addr_done_r = done_q;

endmodule

// File: tb/tb_pbch_addr_gen.sv
// -----------------------------------------------------------------------------
// tb_pbch_addr_gen
// Self-checking bench: dut_a uses the default grid, dut_b the degenerate
// two-symbol grid without puncturing. A reference model fills a scoreboard
// queue at every start; monitors pop and compare on every handshake.
// -----------------------------------------------------------------------------
module tb_pbch_addr_gen;
  import pbch_pkg::*;

  typedef struct {
    int addr;
    int grp;
    bit last;
    int k;
    bit dmrs;
  } exp_t;

  typedef struct {
    int k;
    int n;
    int a0;
    int a1;
    int a2;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  exp_t sb_a[$];
  exp_t sb_b[$];
  exp_t model_q[$];
  vec_t vecs[4];

  int   cnt_a, cnt_b, done_cnt_a, done_cnt_b, done_cyc_a, first_vld_a, dmrs_grp_a;
  int   start_cyc;
  bit   rand_rdy = 1'b0;
  logic [15:0] done_outs_a;
  int   cap_addr[240][3];
  int   cap_n[240];

  pbch_addr_gen_if #(.ADDR_W(10), .SC_W(8)) if_a ();
  pbch_addr_gen_if #(.ADDR_W(10), .SC_W(8)) if_b ();

  pbch_addr_gen #(
    .N_SC(240), .N_SYM(3), .MID_SYM(1), .EDGE_LO(48), .EDGE_HI(192), .ADDR_W(10),
    .SYM_BASE({10'd576, 10'd336, 10'd240, 10'd0})
  ) dut_a (.clk(clk), .rst(rst), .bus(if_a));

  pbch_addr_gen #(
    .N_SC(240), .N_SYM(2), .MID_SYM(1), .EDGE_LO(48), .EDGE_HI(48), .ADDR_W(10),
    .SYM_BASE({10'd0, 10'd0, 10'd240, 10'd0})
  ) dut_b (.clk(clk), .rst(rst), .bus(if_b));

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference grid: present symbols per k and their packed addresses.
  task automatic build_model(input int n_sym, input int mid, input int lo, input int hi,
                             input int b0, input int b1, input int b2, input int b3,
                             input int shift);
    int   base[4];
    int   n;
    int   c;
    exp_t e;
    base[0] = b0; base[1] = b1; base[2] = b2; base[3] = b3;
    model_q.delete();
    for (int k = 0; k < 240; k++) begin
      n = 0;
      for (int s = 0; s < n_sym; s++) if (!(s == mid && k >= lo && k < hi)) n++;
      c = 0;
      for (int s = 0; s < n_sym; s++) begin
        if (!(s == mid && k >= lo && k < hi)) begin
          c++;
          e.addr = base[s] + k - ((s == mid && k >= hi) ? (hi - lo) : 0);
          e.grp  = n;
          e.last = (c == n);
          e.k    = k;
          e.dmrs = ((k % 4) == shift);
          model_q.push_back(e);
        end
      end
    end
  endtask

  task automatic clear_run();
    cnt_a = 0; cnt_b = 0; done_cnt_a = 0; done_cnt_b = 0;
    done_cyc_a = -1; first_vld_a = -1; dmrs_grp_a = 0;
    done_outs_a = '0;
    for (int k = 0; k < 240; k++) begin
      cap_n[k] = 0;
      for (int j = 0; j < 3; j++) cap_addr[k][j] = -1;
    end
  endtask

  task automatic do_start(input logic [1:0] sh, input bit with_b);
    @(negedge clk);
    if_a.start = 1'b1;
    if_a.dmrs_shift = sh;
    if (with_b) begin
      if_b.start = 1'b1;
      if_b.dmrs_shift = sh;
    end
    @(posedge clk);
    #1;
    if_a.start = 1'b0;
    if_b.start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (done_cnt_a == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    @(negedge clk);
    chk({name, "_done_seen"}, 64'(done_cnt_a), 64'd1);
  endtask

  task automatic wait_k(input int k, input int budget);
    int n;
    n = 0;
    while (int'(if_a.sc_idx_r) != k && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_k_reached", 64'(if_a.sc_idx_r), 64'(k));
  endtask

  task automatic check_full_run(input string name);
    chk({name, "_count"}, 64'(cnt_a), 64'd576);
    chk({name, "_sb_empty"}, 64'(sb_a.size()), 64'd0);
    chk({name, "_done_latency"}, 64'(done_cyc_a - start_cyc), 64'd576);
  endtask

  // Downstream ready: always high, or a fair coin flip each cycle.
  initial forever begin
    @(posedge clk);
    #1;
    if_a.out_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // dut_a monitor: scoreboard pops, stall stability, done-cycle outputs.
  initial begin : mon_a
    exp_t e;
    bit   stall;
    logic [31:0] held;
    logic [31:0] now;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      now = {if_a.addr_r, if_a.out_vld_r, if_a.grp_size_r, if_a.grp_last_r,
             if_a.sc_idx_r, if_a.is_dmrs_r, if_a.busy_r, 7'd0};
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) chk("stall_hold_a", 64'(now), 64'(held));
        if (if_a.out_vld_r && if_a.out_rdy) begin
          if (first_vld_a < 0) first_vld_a = cyc;
          if (sb_a.size() == 0) begin
            chk("extra_entry_a", 64'(cnt_a), 64'd576);
          end else begin
            e = sb_a.pop_front();
            chk($sformatf("entry_a k=%0d", e.k),
                64'({if_a.addr_r, if_a.grp_size_r, if_a.grp_last_r, if_a.sc_idx_r,
                     if_a.is_dmrs_r, if_a.busy_r}),
                64'({10'(e.addr), 3'(e.grp), e.last, 8'(e.k), e.dmrs, 1'b1}));
          end
          if (cap_n[if_a.sc_idx_r] < 3) cap_addr[if_a.sc_idx_r][cap_n[if_a.sc_idx_r]] = int'(if_a.addr_r);
          cap_n[if_a.sc_idx_r]++;
          if (if_a.grp_last_r && if_a.is_dmrs_r) dmrs_grp_a++;
          cnt_a++;
          stall = 1'b0;
        end else if (if_a.out_vld_r) begin
          stall = 1'b1;
          held  = now;
        end else begin
          stall = 1'b0;
        end
        if (if_a.addr_done_r) begin
          done_cnt_a++;
          done_cyc_a  = cyc;
          done_outs_a = {if_a.out_vld_r, if_a.addr_r, if_a.busy_r, if_a.grp_last_r, 3'd0};
        end
      end
    end
  end

  // dut_b monitor: always-ready consumer.
  initial begin : mon_b
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (if_b.out_vld_r && if_b.out_rdy) begin
          if (sb_b.size() == 0) begin
            chk("extra_entry_b", 64'(cnt_b), 64'd480);
          end else begin
            e = sb_b.pop_front();
            chk($sformatf("entry_b k=%0d", e.k),
                64'({if_b.addr_r, if_b.grp_size_r, if_b.grp_last_r, if_b.sc_idx_r}),
                64'({10'(e.addr), 3'(e.grp), e.last, 8'(e.k)}));
          end
          cnt_b++;
        end
        if (if_b.addr_done_r) done_cnt_b++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{k: 0,   n: 3, a0: 0,   a1: 240, a2: 336};
    vecs[1] = '{k: 48,  n: 2, a0: 48,  a1: 384, a2: 0};
    vecs[2] = '{k: 192, n: 3, a0: 192, a1: 288, a2: 528};
    vecs[3] = '{k: 239, n: 3, a0: 239, a1: 335, a2: 575};

    if_a.start = 1'b0; if_a.dmrs_shift = 2'd0; if_a.out_rdy = 1'b1;
    if_b.start = 1'b0; if_b.dmrs_shift = 2'd0; if_b.out_rdy = 1'b1;
    clear_run();

    // Reset state.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_addr",     64'(if_a.addr_r),      64'(PBCH_ADDR_IDLE));
    chk("rst_vld",      64'(if_a.out_vld_r),   64'd0);
    chk("rst_grp_size", 64'(if_a.grp_size_r),  64'd3);
    chk("rst_grp_last", 64'(if_a.grp_last_r),  64'd0);
    chk("rst_sc_idx",   64'(if_a.sc_idx_r),    64'd0);
    chk("rst_is_dmrs",  64'(if_a.is_dmrs_r),   64'd0);
    chk("rst_busy",     64'(if_a.busy_r),      64'd0);
    chk("rst_done",     64'(if_a.addr_done_r), 64'd0);
    chk("rst_grp_size_b", 64'(if_b.grp_size_r), 64'd2);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Run 1: default grid plus degenerate grid, always ready.
    clear_run();
    build_model(3, 1, 48, 192, 0, 240, 336, 576, 0);
    sb_a = model_q;
    build_model(2, 1, 48, 48, 0, 240, 0, 0, 0);
    sb_b = model_q;
    do_start(2'd0, 1'b1);
    wait_done("run1", 1000);
    check_full_run("run1");
    chk("run1_first_latency", 64'(first_vld_a - start_cyc), 64'd0);
    chk("run1_done_pulse_width", 64'(done_cnt_a), 64'd1);
    chk("run1_done_outputs", 64'(done_outs_a), 64'({1'b0, 10'h3ff, 1'b0, 1'b0, 3'd0}));
    chk("run1_idle_after_done", 64'({if_a.out_vld_r, if_a.addr_done_r, if_a.busy_r}), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("vec k=%0d size", vecs[i].k), 64'(cap_n[vecs[i].k]), 64'(vecs[i].n));
      chk($sformatf("vec k=%0d a0", vecs[i].k), 64'(cap_addr[vecs[i].k][0]), 64'(vecs[i].a0));
      chk($sformatf("vec k=%0d a1", vecs[i].k), 64'(cap_addr[vecs[i].k][1]), 64'(vecs[i].a1));
      if (vecs[i].n == 3)
        chk($sformatf("vec k=%0d a2", vecs[i].k), 64'(cap_addr[vecs[i].k][2]), 64'(vecs[i].a2));
    end
    chk("run1_b_count", 64'(cnt_b), 64'd480);
    chk("run1_b_sb_empty", 64'(sb_b.size()), 64'd0);
    chk("run1_b_done", 64'(done_cnt_b), 64'd1);

    // Run 2: DMRS offset 2.
    clear_run();
    build_model(3, 1, 48, 192, 0, 240, 336, 576, 2);
    sb_a = model_q;
    do_start(2'd2, 1'b0);
    wait_done("run2", 1000);
    check_full_run("run2");
    chk("run2_dmrs_groups", 64'(dmrs_grp_a), 64'd60);

    // Run 3: random back-pressure.
    clear_run();
    build_model(3, 1, 48, 192, 0, 240, 336, 576, 1);
    sb_a = model_q;
    rand_rdy = 1'b1;
    do_start(2'd1, 1'b0);
    wait_done("run3", 6000);
    rand_rdy = 1'b0;
    chk("run3_count", 64'(cnt_a), 64'd576);
    chk("run3_sb_empty", 64'(sb_a.size()), 64'd0);
    repeat (2) @(negedge clk);

    // Run 4: a second start mid-sweep must be ignored.
    clear_run();
    build_model(3, 1, 48, 192, 0, 240, 336, 576, 0);
    sb_a = model_q;
    do_start(2'd0, 1'b0);
    wait_k(100, 1000);
    if_a.start = 1'b1;
    if_a.dmrs_shift = 2'd3;
    @(negedge clk);
    if_a.start = 1'b0;
    wait_done("run4", 1000);
    check_full_run("run4");

    // Run 5: reset mid-sweep aborts silently, next start begins at address 0.
    clear_run();
    build_model(3, 1, 48, 192, 0, 240, 336, 576, 0);
    sb_a = model_q;
    do_start(2'd0, 1'b0);
    wait_k(120, 1000);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb_a.delete();
    repeat (5) @(negedge clk);
    chk("run5_no_done_pulse", 64'(done_cnt_a), 64'd0);
    chk("run5_idle_outputs", 64'({if_a.out_vld_r, if_a.addr_r, if_a.busy_r, if_a.sc_idx_r}),
        64'({1'b0, 10'h3ff, 1'b0, 8'd0}));
    clear_run();
    build_model(3, 1, 48, 192, 0, 240, 336, 576, 0);
    sb_a = model_q;
    do_start(2'd0, 1'b0);
    wait_done("run5", 1000);
    check_full_run("run5");
    chk("run5_restart_addr0", 64'(cap_addr[0][0]), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
